// File: rtl/stopwatch_timer_pkg.sv
// Shared widths, limits, state encoding and divider helpers for the stopwatch time-base.
package stopwatch_timer_pkg;

  localparam int HOUR_W = 6;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int CS_W   = 7;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int CS_MAX  = 99;

  localparam logic [0:0] ST_LIVE = 1'b0;
  localparam logic [0:0] ST_LAP  = 1'b1;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic [CS_W-1:0]   cs;
  } time_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold 0..max_val; a counter that only ever holds 0 still needs one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_timer_if.sv
// Control inputs and displayed time outputs of the stopwatch time-base.
interface stopwatch_timer_if;
  import stopwatch_timer_pkg::*;

  // Level/pulse controls from the key FSM; no handshake: a pulse is acted on in
  // the single cycle it is high, and run_timer is sampled every cycle.
  logic              run_timer;
  logic              clear_timer;
  logic              lap_pulse;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  minute;
  logic [SEC_W-1:0]  second;
  logic [CS_W-1:0]   m_sec;
  logic              lap_active;
  logic              tick;
  logic              rollover;
  logic [0:0]        state_dbg;

  modport master (
    output run_timer, clear_timer, lap_pulse,
    input  hour, minute, second, m_sec, lap_active, tick, rollover, state_dbg
  );

  modport slave (
    input  run_timer, clear_timer, lap_pulse,
    output hour, minute, second, m_sec, lap_active, tick, rollover, state_dbg
  );

endinterface

// File: rtl/stopwatch_timer_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry flags the increment that wraps it.
module mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & (value_q == MAX_V);

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch time-base: prescaled centisecond tick, h:m:s.cs carry chain and lap snapshot.
module stopwatch_timer
  import stopwatch_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 100,
  parameter int HOUR_MAX    = 23
) (
  input  logic              clock,
  input  logic              reset_n,
  stopwatch_timer_if.slave  bus
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int PRE_W = cnt_width(DIV - 1);

  logic [PRE_W-1:0]  pre_val;
  logic [CS_W-1:0]   cs_val;
  logic [SEC_W-1:0]  sec_val;
  logic [MIN_W-1:0]  min_val;
  logic [HOUR_W-1:0] hour_val;
  logic pre_carry, cs_carry, sec_carry, min_carry, hour_carry;

  mod_counter #(.WIDTH(PRE_W), .MAX(DIV - 1)) u_pre (
    .clk(clock), .rst_n(reset_n), .inc(bus.run_timer), .clr(bus.clear_timer),
    .value(pre_val), .carry(pre_carry)
  );

  mod_counter #(.WIDTH(CS_W), .MAX(CS_MAX)) u_cs (
    .clk(clock), .rst_n(reset_n), .inc(pre_carry), .clr(bus.clear_timer),
    .value(cs_val), .carry(cs_carry)
  );

  mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clock), .rst_n(reset_n), .inc(cs_carry), .clr(bus.clear_timer),
    .value(sec_val), .carry(sec_carry)
  );

  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clock), .rst_n(reset_n), .inc(sec_carry), .clr(bus.clear_timer),
    .value(min_val), .carry(min_carry)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clock), .rst_n(reset_n), .inc(min_carry), .clr(bus.clear_timer),
    .value(hour_val), .carry(hour_carry)
  );

  time_t      live;
  time_t      snap_q, snap_d;
  time_t      disp;
  logic [0:0] state_q, state_d;
  logic       tick_q, tick_d;
  logic       rollover_q, rollover_d;

  assign live = '{hour: hour_val, minute: min_val, second: sec_val, cs: cs_val};

  // Clear outranks lap; the snapshot takes the live count as it stood before this edge.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    tick_d     = pre_carry & ~bus.clear_timer;
    rollover_d = hour_carry & ~bus.clear_timer;
    if (bus.clear_timer) begin
      state_d = ST_LIVE;
      snap_d  = '0;
    end else if (bus.lap_pulse) begin
      if (state_q == ST_LIVE) begin
        state_d = ST_LAP;
        snap_d  = live;
      end else begin
        state_d = ST_LIVE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LIVE;
      snap_q     <= '0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
    end
  end

  always_comb begin
    disp = (state_q == ST_LAP) ? snap_q : live;
  end

  assign bus.hour       = disp.hour;
  assign bus.minute     = disp.minute;
  assign bus.second     = disp.second;
  assign bus.m_sec      = disp.cs;
  assign bus.lap_active = (state_q == ST_LAP);
  assign bus.tick       = tick_q;
  assign bus.rollover   = rollover_q;
  assign bus.state_dbg  = state_q;

endmodule
